button_conditioner_bank: RTL

//  N-channel push-button front end: per channel 2-FF synchroniser, counter debouncer, edge detector.

---
 rtl/button_conditioner_bank.sv | 134 +++++++++++++
 1 files changed

// File: rtl/button_conditioner_bank.sv
// N-channel push-button conditioner: 2-FF synchroniser, counter debouncer and
// edge detector per channel, with registered press/release strobes.
// Optional auto-repeat while held is enabled by defining HOLD_REPEAT_EN.
module button_conditioner_bank #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned DB_CYCLES     = 500000,
  parameter int unsigned ACTIVE_LOW_IN = 0,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_press
);

  localparam int unsigned     CntW   = $clog2(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);
  localparam logic            InvIn  = (ACTIVE_LOW_IN != 0);
  // Raw level of a released button, so the synchroniser restarts "not pressed".
  localparam logic [N_CH-1:0] IdleRaw = {N_CH{InvIn}};

  logic [N_CH-1:0] s1_q, s2_q;
  logic [N_CH-1:0] pressed;
  logic [CntW-1:0] cnt_q [N_CH];
  logic [CntW-1:0] cnt_d [N_CH];
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] release_q, release_d;
  logic            any_q;

  assign pressed = s2_q ^ {N_CH{InvIn}};

  // Debounce: level follows pressed only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i]   = pressed[i];
          press_d[i]   = pressed[i];
          release_d[i] = ~pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Synchroniser, debounce counters, level and strobe registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q      <= IdleRaw;
      s2_q      <= IdleRaw;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= btn_in;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= |press_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign any_press     = any_q;

`ifdef HOLD_REPEAT_EN
  localparam int unsigned HoldMax  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HoldW    = (HoldMax > 2) ? $clog2(HoldMax) : 1;
  localparam logic [HoldW-1:0] DelayLast  = HoldW'(REPEAT_DELAY - 1);
  localparam logic [HoldW-1:0] PeriodLast = HoldW'(REPEAT_PERIOD - 1);

  logic [HoldW-1:0] hold_q [N_CH];
  logic [HoldW-1:0] hold_d [N_CH];
  logic [N_CH-1:0]  first_q, first_d;
  logic [N_CH-1:0]  repeat_q, repeat_d;

  // Hold timer: runs only while held both before and after this edge, so a press
  // edge restarts it and a release edge cancels a strobe due in the same cycle.
  always_comb begin
    first_d  = first_q;
    repeat_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      hold_d[i] = hold_q[i];
      if (!level_q[i] || !level_d[i]) begin
        hold_d[i]  = '0;
        first_d[i] = 1'b1;
      end else if (hold_q[i] == (first_q[i] ? DelayLast : PeriodLast)) begin
        hold_d[i]   = '0;
        first_d[i]  = 1'b0;
        repeat_d[i] = 1'b1;
      end else begin
        hold_d[i] = hold_q[i] + HoldW'(1);
      end
    end
  end

  // Hold counter and repeat strobe registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      first_q  <= '1;
      repeat_q <= '0;
      for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
    end else begin
      first_q  <= first_d;
      repeat_q <= repeat_d;
      for (int i = 0; i < N_CH; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign repeat_pulse = repeat_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign repeat_pulse      = '0;
`endif

endmodule
